// File: rtl/sap1_acc_if.sv
// sap1_acc_if: control-word, W-bus and adder signals of the SAP-1 accumulator stage
interface sap1_acc_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] bus_in;
  logic             la;
  logic             lb;
  logic             ea;
  logic             eu;
  logic             add_req;
  logic             add_wb;
  logic [WIDTH-1:0] x_out;
  logic [WIDTH-1:0] y_out;
  logic [WIDTH-1:0] sum_in;
  logic             co_in;
  logic             busy;
  logic             add_done;
  logic [WIDTH-1:0] bus_out;
  logic             bus_oe;
  logic             carry_flag;
  logic             zero_flag;
  modport master (
    output bus_in, la, lb, ea, eu, add_req, add_wb, sum_in, co_in,
    input  x_out, y_out, busy, add_done, bus_out, bus_oe, carry_flag, zero_flag
  );
  modport slave (
    input  bus_in, la, lb, ea, eu, add_req, add_wb, sum_in, co_in,
    output x_out, y_out, busy, add_done, bus_out, bus_oe, carry_flag, zero_flag
  );
endinterface

// File: rtl/sap1_acc_stage.sv
// sap1_acc_stage: A/B/R registers around the ripple adder with a multi-cycle settle sequencer; SAP1_ACC_FLAGS_EN adds carry/zero flags
module sap1_acc_stage #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  sap1_acc_if.slave   io
);
  typedef enum logic {IDLE, SETTLE} state_t;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic             wb_q, wb_d, done_q, done_d;
  logic             capture;
  assign capture = (state_q == SETTLE) && (cnt_q == 4'd0);
  // next state: loads and starts only in IDLE, capture when the settle count expires
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    wb_d    = wb_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      a_d = io.la ? io.bus_in : a_q;
      b_d = io.lb ? io.bus_in : b_q;
      if (io.add_req) begin
        state_d = SETTLE;
        cnt_d   = 4'(SETTLE_CYCLES - 1);
        wb_d    = io.add_wb;
      end
    end else if (capture) begin
      r_d     = io.sum_in;
      a_d     = wb_q ? io.sum_in : a_q;
      done_d  = 1'b1;
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q - 4'd1;
    end
  end
  // state registers; reset aborts any addition in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      wb_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      wb_q    <= wb_d;
      done_q  <= done_d;
    end
  end
`ifdef SAP1_ACC_FLAGS_EN
  logic carry_q, carry_d, zero_q, zero_d;
  // flags follow the adder only at capture and hold otherwise
  always_comb begin
    carry_d = capture ? io.co_in : carry_q;
    zero_d  = capture ? (io.sum_in == '0) : zero_q;
  end
  // flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end
  assign io.carry_flag = carry_q;
  assign io.zero_flag  = zero_q;
`else
  assign io.carry_flag = 1'b0;
  assign io.zero_flag  = 1'b0;
`endif
  assign io.x_out    = a_q;
  assign io.y_out    = b_q;
  assign io.busy     = (state_q == SETTLE);
  assign io.add_done = done_q;
  assign io.bus_oe   = io.ea | io.eu;
  assign io.bus_out  = io.eu ? r_q : io.ea ? a_q : '0;
endmodule

// File: tb/tb_sap1_acc_stage.sv
// tb_sap1_acc_stage: scoreboard bench for sap1_acc_stage with a behavioural ripple adder
module tb_sap1_acc_stage;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [8:0] sb[$];
  logic [8:0] full;
  sap1_acc_if #(.WIDTH(8)) io();
  sap1_acc_stage #(.WIDTH(8), .SETTLE_CYCLES(S)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  assign full      = {1'b0, io.x_out} + {1'b0, io.y_out};
  assign io.sum_in = full[7:0];
  assign io.co_in  = full[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    io.la = 0; io.lb = 0; io.ea = 0; io.eu = 0; io.add_req = 0; io.add_wb = 0; io.bus_in = '0;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    io.la = 1; io.bus_in = a; tick(); io.la = 0;
    io.lb = 1; io.bus_in = b; tick(); io.lb = 0;
  endtask

  task automatic start_add(input logic wb, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    sb.push_back(s);
    io.add_req = 1; io.add_wb = wb; tick(); io.add_req = 0; io.add_wb = 0;
  endtask

  task automatic wait_done(output int bc, output bit ok);
    bc = 0; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (io.add_done) ok = 1;
      else begin
        if (io.busy) bc++;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; io.la = 1; io.ea = 1; io.bus_in = 8'h77; tick(); #1;
    n_tests++; if (io.bus_out !== 8'h00) begin n_fail++; $display("FAIL reset_bus got %h want 00", io.bus_out); end
    n_tests++; if (io.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", io.busy); end
    n_tests++; if (io.add_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", io.add_done); end
    n_tests++; if ({io.carry_flag, io.zero_flag} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {io.carry_flag, io.zero_flag}); end
    rst = 0; io.bus_in = 8'h12; tick(); io.la = 0; #1;
    n_tests++; if (io.bus_out !== 8'h12) begin n_fail++; $display("FAIL load_a got %h want 12", io.bus_out); end
    n_tests++; if (io.bus_oe !== 1'b1) begin n_fail++; $display("FAIL bus_oe_ea got %b want 1", io.bus_oe); end
    io.ea = 0; #1;
    n_tests++; if ({io.bus_oe, io.bus_out} !== 9'h000) begin n_fail++; $display("FAIL bus_off got %h want 000", {io.bus_oe, io.bus_out}); end
  endtask

  task automatic test_add();
    int bc; bit ok; logic [8:0] e;
    load(8'h12, 8'h34);
    start_add(0, 8'h12, 8'h34);
    wait_done(bc, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL add_done_timeout got 0 want 1"); end
    n_tests++; if (bc !== S) begin n_fail++; $display("FAIL add_busy_cycles got %0d want %0d", bc, S); end
    e = sb.pop_front();
    io.eu = 1; #1;
    n_tests++; if (io.bus_out !== e[7:0]) begin n_fail++; $display("FAIL add_r got %h want %h", io.bus_out, e[7:0]); end
    io.eu = 0; io.ea = 1; #1;
    n_tests++; if (io.bus_out !== 8'h12) begin n_fail++; $display("FAIL add_a_kept got %h want 12", io.bus_out); end
`ifdef SAP1_ACC_FLAGS_EN
    n_tests++; if (io.carry_flag !== e[8]) begin n_fail++; $display("FAIL add_carry got %b want %b", io.carry_flag, e[8]); end
`endif
    io.ea = 0; tick();
    n_tests++; if (io.add_done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got %b want 0", io.add_done); end
  endtask

  task automatic test_writeback();
    int bc; bit ok; logic [8:0] e; logic ec, ez;
    load(8'hFF, 8'h01);
    start_add(1, 8'hFF, 8'h01);
    wait_done(bc, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL wb_done_timeout got 0 want 1"); end
    e = sb.pop_front();
`ifdef SAP1_ACC_FLAGS_EN
    ec = e[8]; ez = (e[7:0] == 8'h00);
`else
    ec = 0; ez = 0;
`endif
    io.eu = 1; #1;
    n_tests++; if (io.bus_out !== e[7:0]) begin n_fail++; $display("FAIL wb_r got %h want %h", io.bus_out, e[7:0]); end
    io.eu = 0; io.ea = 1; #1;
    n_tests++; if (io.bus_out !== e[7:0]) begin n_fail++; $display("FAIL wb_a got %h want %h", io.bus_out, e[7:0]); end
    n_tests++; if (io.carry_flag !== ec) begin n_fail++; $display("FAIL wb_carry got %b want %b", io.carry_flag, ec); end
    n_tests++; if (io.zero_flag !== ez) begin n_fail++; $display("FAIL wb_zero got %b want %b", io.zero_flag, ez); end
    io.ea = 0; tick();
  endtask

  task automatic test_ignore_during_settle();
    int dones = 0; logic [8:0] e;
    load(8'h20, 8'h03);
    start_add(0, 8'h20, 8'h03);
    n_tests++; if (io.busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy got %b want 1", io.busy); end
    io.la = 1; io.bus_in = 8'h55; io.add_req = 1; tick(); io.la = 0; io.add_req = 0;
    for (int i = 0; i < 10; i++) begin
      if (io.add_done) begin
        dones++;
        if (sb.size() != 0) begin
          e = sb.pop_front(); io.eu = 1; #1;
          n_tests++; if (io.bus_out !== e[7:0]) begin n_fail++; $display("FAIL ign_r got %h want %h", io.bus_out, e[7:0]); end
          io.eu = 0;
        end
      end
      tick();
    end
    n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL ign_done_count got %0d want 1", dones); end
    io.ea = 1; #1;
    n_tests++; if (io.bus_out !== 8'h20) begin n_fail++; $display("FAIL ign_a got %h want 20", io.bus_out); end
    io.ea = 0;
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    load(8'h01, 8'h02);
    io.add_req = 1; io.add_wb = 1; tick(); io.add_req = 0; io.add_wb = 0;
    rst = 1; tick(); rst = 0;
    n_tests++; if (io.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", io.busy); end
    io.eu = 1; #1;
    n_tests++; if (io.bus_out !== 8'h00) begin n_fail++; $display("FAIL abort_r got %h want 00", io.bus_out); end
    io.eu = 0;
    for (int i = 0; i < 6; i++) begin
      if (io.add_done) dones++;
      tick();
    end
    n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", dones); end
    io.ea = 1; #1;
    n_tests++; if (io.bus_out !== 8'h00) begin n_fail++; $display("FAIL abort_a got %h want 00", io.bus_out); end
    io.ea = 0;
  endtask

  task automatic test_back_to_back();
    int bc; bit ok; logic [8:0] e;
    load(8'h0A, 8'h01);
    start_add(0, 8'h0A, 8'h01);
    wait_done(bc, ok);
    e = sb.pop_front();
    tick();
    io.ea = 1; io.eu = 1; #1;
    n_tests++; if (io.bus_out !== e[7:0]) begin n_fail++; $display("FAIL prio_bus got %h want %h", io.bus_out, e[7:0]); end
    n_tests++; if (io.bus_oe !== 1'b1) begin n_fail++; $display("FAIL prio_oe got %b want 1", io.bus_oe); end
    io.ea = 0; io.eu = 0;
    start_add(1, 8'h0A, 8'h01);
    wait_done(bc, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_first_timeout got 0 want 1"); end
    e = sb.pop_front();
    start_add(0, e[7:0], 8'h01);
    n_tests++; if (io.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart got %b want 1", io.busy); end
    wait_done(bc, ok);
    n_tests++; if (!ok || bc !== S) begin n_fail++; $display("FAIL b2b_second got ok=%0d busy=%0d want ok=1 busy=%0d", ok, bc, S); end
    e = sb.pop_front();
    io.eu = 1; #1;
    n_tests++; if (io.bus_out !== e[7:0]) begin n_fail++; $display("FAIL b2b_r got %h want %h", io.bus_out, e[7:0]); end
    io.eu = 0; tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_add();
    test_writeback();
    test_ignore_during_settle();
    test_reset_abort();
    test_back_to_back();
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_empty got %0d want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
